// File: rtl/mips_defs.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs,
// FSM state codes, datapath mux selects and the decoded instruction class.
package mips_defs;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type functs
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // FSM states (visible on the debug port, so the codes are fixed)
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXE    = 3'd2;
  localparam logic [2:0] S_MEM_RD = 3'd3;
  localparam logic [2:0] S_MEM_WR = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  // pc_src
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  // rf_wa_sel
  localparam logic [1:0] WA_RT = 2'd0;
  localparam logic [1:0] WA_RD = 2'd1;
  localparam logic [1:0] WA_RA = 2'd2;

  // rf_wd_sel
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  // ext_op
  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  // alu_op
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;

  // One-hot instruction class; all-zero means unsupported encoding
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic nop;
  } icls_t;

  // Full control word driven to the datapath
  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       rf_we;
    logic [1:0] rf_wa_sel;
    logic [1:0] rf_wd_sel;
    logic [1:0] ext_op;
    logic       alu_b_sel;
    logic [2:0] alu_op;
    logic       mem_re;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       done;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: IR word -> one-hot class + illegal.
module mc_decode
  import mips_defs::*;
(
  input  logic [31:0] instr,
  output icls_t       cls,
  output logic        illegal
);

  logic [5:0] op;
  logic [5:0] fn;

  assign op = instr[31:26];
  assign fn = instr[5:0];

  // nop is only the all-zero word; any other R-type funct is unsupported
  always_comb begin
    cls = '0;
    if (instr == 32'h0) begin
      cls.nop = 1'b1;
    end else begin
      case (op)
        OP_RTYPE: begin
          case (fn)
            FN_ADDU: cls.addu = 1'b1;
            FN_SUBU: cls.subu = 1'b1;
            FN_JR:   cls.jr   = 1'b1;
            default: ;
          endcase
        end
        OP_ORI:  cls.ori = 1'b1;
        OP_LUI:  cls.lui = 1'b1;
        OP_LW:   cls.lw  = 1'b1;
        OP_SW:   cls.sw  = 1'b1;
        OP_BEQ:  cls.beq = 1'b1;
        OP_J:    cls.j   = 1'b1;
        OP_JAL:  cls.jal = 1'b1;
        default: ;
      endcase
    end
  end

  assign illegal = ~|cls;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: state register, per-state control decode
// and retired-instruction counter.
module mc_ctrl
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        ir_we,
  output logic        rf_we,
  output logic [1:0]  rf_wa_sel,
  output logic [1:0]  rf_wd_sel,
  output logic [1:0]  ext_op,
  output logic        alu_b_sel,
  output logic [2:0]  alu_op,
  output logic        mem_re,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [2:0]  state,
  output logic        instr_done,
  output logic        illegal,
  output logic [31:0] instr_cnt
);

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [31:0] cnt_q;
  icls_t       cls;
  logic        dec_ill;
  ctrl_t       c;

  mc_decode u_dec (
    .instr   (instr),
    .cls     (cls),
    .illegal (dec_ill)
  );

  // Next state and control word; reset low masks every side effect
  always_comb begin
    c       = '0;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        c.mem_re = 1'b1;
        if (mem_ready) begin
          c.ir_we  = 1'b1;
          c.pc_we  = 1'b1;
          c.pc_src = PC_PLUS4;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_FETCH;
        if (cls.j) begin
          c.pc_we  = 1'b1;
          c.pc_src = PC_JUMP;
          c.done   = 1'b1;
        end else if (cls.jal) begin
          c.pc_we     = 1'b1;
          c.pc_src    = PC_JUMP;
          c.rf_we     = 1'b1;
          c.rf_wa_sel = WA_RA;
          c.rf_wd_sel = WD_PC4;
          c.done      = 1'b1;
        end else if (cls.nop) begin
          c.done = 1'b1;
        end else if (dec_ill) begin
          c.illegal = 1'b1;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        state_d = S_FETCH;
        if (cls.addu || cls.subu) begin
          c.alu_op = cls.subu ? ALU_SUB : ALU_ADD;
          state_d  = S_WB;
        end else if (cls.ori || cls.lui) begin
          c.alu_op    = ALU_OR;
          c.ext_op    = cls.lui ? EXT_LUI : EXT_ZERO;
          c.alu_b_sel = 1'b1;
          state_d     = S_WB;
        end else if (cls.lw || cls.sw) begin
          c.alu_op    = ALU_ADD;
          c.ext_op    = EXT_SIGN;
          c.alu_b_sel = 1'b1;
          state_d     = cls.lw ? S_MEM_RD : S_MEM_WR;
        end else if (cls.beq) begin
          c.alu_op = ALU_SUB;
          c.pc_we  = zero;
          c.pc_src = zero ? PC_BRANCH : PC_PLUS4;
          c.done   = 1'b1;
        end else if (cls.jr) begin
          c.pc_we  = 1'b1;
          c.pc_src = PC_RS;
          c.done   = 1'b1;
        end
      end
      S_MEM_RD: begin
        c.mem_re       = 1'b1;
        c.mem_addr_sel = 1'b1;
        if (mem_ready) state_d = S_WB;
      end
      S_MEM_WR: begin
        c.mem_we       = 1'b1;
        c.mem_addr_sel = 1'b1;
        if (mem_ready) begin
          c.done  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        c.rf_we     = 1'b1;
        c.rf_wa_sel = (cls.addu || cls.subu) ? WA_RD : WA_RT;
        c.rf_wd_sel = cls.lw ? WD_MEM : WD_ALU;
        c.done      = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (!reset) begin
      c.pc_we   = 1'b0;
      c.ir_we   = 1'b0;
      c.rf_we   = 1'b0;
      c.mem_re  = 1'b0;
      c.mem_we  = 1'b0;
      c.done    = 1'b0;
      c.illegal = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Retired-instruction counter; only written on a retire so it wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt_q <= '0;
    else if (c.done) cnt_q <= cnt_q + 32'd1;
  end

  assign pc_we        = c.pc_we;
  assign pc_src       = c.pc_src;
  assign ir_we        = c.ir_we;
  assign rf_we        = c.rf_we;
  assign rf_wa_sel    = c.rf_wa_sel;
  assign rf_wd_sel    = c.rf_wd_sel;
  assign ext_op       = c.ext_op;
  assign alu_b_sel    = c.alu_b_sel;
  assign alu_op       = c.alu_op;
  assign mem_re       = c.mem_re;
  assign mem_we       = c.mem_we;
  assign mem_addr_sel = c.mem_addr_sel;
  assign instr_done   = c.done;
  assign illegal      = c.illegal;
  assign state        = state_q;
  assign instr_cnt    = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed scenarios plus random instruction streams,
// checked against a per-instruction trace/event model.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_we, ir_we, rf_we, alu_b_sel, mem_re, mem_we, mem_addr_sel;
  logic        instr_done, illegal;
  logic [1:0]  pc_src, rf_wa_sel, rf_wd_sel, ext_op;
  logic [2:0]  alu_op, state;
  logic [31:0] instr_cnt;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] cnt_model = '0;

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5,
                 K_BEQ = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_NOP = 10, K_ILL = 11;
  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, MR = 3'd3, MW = 3'd4, W = 3'd5;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .rf_we(rf_we),
    .rf_wa_sel(rf_wa_sel), .rf_wd_sel(rf_wd_sel), .ext_op(ext_op),
    .alu_b_sel(alu_b_sel), .alu_op(alu_op), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .state(state), .instr_done(instr_done),
    .illegal(illegal), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input int k);
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    rs  = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    imm = 16'($urandom); tgt = 26'($urandom);
    case (k)
      K_ADDU: return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      K_SUBU: return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      K_ORI:  return {6'h0D, rs, rt, imm};
      K_LUI:  return {6'h0F, 5'd0, rt, imm};
      K_LW:   return {6'h23, rs, rt, imm};
      K_SW:   return {6'h2B, rs, rt, imm};
      K_BEQ:  return {6'h04, rs, rt, imm};
      K_J:    return {6'h02, tgt};
      K_JAL:  return {6'h03, tgt};
      K_JR:   return {6'h00, rs, 15'd0, 6'h08};
      K_NOP:  return 32'h0;
      default: return ($urandom_range(0, 1) == 0) ? {6'h3F, tgt}
                                                   : {6'h00, rs, rt, rd, 5'd0, 6'h2A};
    endcase
  endfunction

  // Run one instruction from FETCH; wf/wm = memory stall cycles in FETCH / MEM stage
  task automatic run_instr(input int k, input int wf, input int wm, input logic z,
                           input logic [31:0] w);
    logic [2:0]  tr[$];
    logic        mr[$];
    logic [1:0]  e_pc[$], g_pc[$];
    logic [3:0]  e_rf[$], g_rf[$];
    logic [7:0]  e_exe;
    logic        retire;
    int          n;
    for (int i = 0; i < wf; i++) begin tr.push_back(F); mr.push_back(1'b0); end
    tr.push_back(F); mr.push_back(1'b1);
    tr.push_back(D); mr.push_back(1'($urandom));
    e_pc.push_back(2'd0);
    retire = (k != K_ILL);
    e_exe  = '0;
    if (k == K_J)   e_pc.push_back(2'd2);
    if (k == K_JAL) begin e_pc.push_back(2'd2); e_rf.push_back({2'd2, 2'd2}); end
    if (!(k inside {K_J, K_JAL, K_NOP, K_ILL})) begin
      tr.push_back(E); mr.push_back(1'($urandom));
      case (k)
        K_ADDU: e_exe = {3'd0, 2'd0, 1'b0, 2'b0};
        K_SUBU: e_exe = {3'd1, 2'd0, 1'b0, 2'b0};
        K_ORI:  e_exe = {3'd2, 2'd0, 1'b1, 2'b0};
        K_LUI:  e_exe = {3'd2, 2'd2, 1'b1, 2'b0};
        K_LW, K_SW: e_exe = {3'd0, 2'd1, 1'b1, 2'b0};
        K_BEQ:  e_exe = {3'd1, 2'd0, 1'b0, 2'b0};
        default: e_exe = '0;
      endcase
      if (k == K_BEQ && z) e_pc.push_back(2'd1);
      if (k == K_JR) e_pc.push_back(2'd3);
      if (k == K_LW || k == K_SW) begin
        for (int i = 0; i < wm; i++) begin tr.push_back(k == K_LW ? MR : MW); mr.push_back(1'b0); end
        tr.push_back(k == K_LW ? MR : MW); mr.push_back(1'b1);
      end
      if (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW}) begin
        tr.push_back(W); mr.push_back(1'($urandom));
        e_rf.push_back({(k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0, (k == K_LW) ? 2'd1 : 2'd0});
      end
    end
    n = tr.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_ready = mr[i];
      instr     = (tr[i] == F) ? $urandom : w;
      zero      = (tr[i] == E) ? z : 1'($urandom);
      #1;
      chk("state", 32'(state), 32'(tr[i]));
      chk("mem", {29'd0, mem_re, mem_we, mem_addr_sel},
          {29'd0, tr[i] == F || tr[i] == MR, tr[i] == MW, tr[i] == MR || tr[i] == MW});
      chk("ir_we", 32'(ir_we), 32'(tr[i] == F && mr[i]));
      chk("done", 32'(instr_done), 32'(i == n - 1 && retire));
      chk("illegal", 32'(illegal), 32'(i == n - 1 && !retire));
      if (tr[i] == E) chk("exe_ctl", {24'd0, alu_op, ext_op, alu_b_sel, 2'b0}, 32'(e_exe));
      if (pc_we) g_pc.push_back(pc_src);
      if (rf_we) g_rf.push_back({rf_wa_sel, rf_wd_sel});
    end
    if (retire) cnt_model = cnt_model + 32'd1;
    chk("pc_we_n", g_pc.size(), e_pc.size());
    for (int i = 0; i < e_pc.size() && i < g_pc.size(); i++) chk("pc_src", 32'(g_pc[i]), 32'(e_pc[i]));
    chk("rf_we_n", g_rf.size(), e_rf.size());
    for (int i = 0; i < e_rf.size() && i < g_rf.size(); i++) chk("rf_sel", 32'(g_rf[i]), 32'(e_rf[i]));
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("instr_cnt", instr_cnt, cnt_model);
  endtask

  initial begin
    // Reset held for 3 cycles: FETCH, counter clear, enables masked
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_state", 32'(state), 0);
      chk("rst_cnt", instr_cnt, 0);
      chk("rst_en", {27'd0, mem_re, mem_we, pc_we, ir_we, rf_we}, 0);
    end
    @(negedge clk); reset = 1'b1;

    // Directed scenarios
    run_instr(K_ADDU, 0, 0, 1'b0, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21});
    run_instr(K_LW,   0, 2, 1'b0, mk_instr(K_LW));
    run_instr(K_BEQ,  0, 0, 1'b1, mk_instr(K_BEQ));
    run_instr(K_BEQ,  0, 0, 1'b0, mk_instr(K_BEQ));
    run_instr(K_JAL,  0, 0, 1'b0, mk_instr(K_JAL));
    run_instr(K_ILL,  0, 0, 1'b0, {6'h3F, 26'h123456});
    run_instr(K_JR,   1, 0, 1'b0, mk_instr(K_JR));
    run_instr(K_SW,   2, 1, 1'b0, mk_instr(K_SW));

    // Random stream
    for (int t = 0; t < 80; t++) begin
      int k;
      k = $urandom_range(0, 11);
      run_instr(k, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), mk_instr(k));
    end

    // Reset asserted during a MEM_WR stall
    @(negedge clk); instr = $urandom; mem_ready = 1'b1;
    @(negedge clk); instr = mk_instr(K_SW);
    @(negedge clk);
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("mw_state", 32'(state), 32'(MW));
    chk("mw_we", 32'(mem_we), 1);
    #2 reset = 1'b0; #1;
    chk("rst_mw_we", 32'(mem_we), 0);
    chk("rst_mw_re", 32'(mem_re), 0);
    chk("rst_mw_state", 32'(state), 0);
    chk("rst_mw_cnt", instr_cnt, 0);
    cnt_model = '0;
    @(negedge clk); reset = 1'b1;

    // Counter wrap from all-ones on a retired nop
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    chk("cnt_forced", instr_cnt, 32'hFFFF_FFFF);
    release dut.cnt_q;
    cnt_model = 32'hFFFF_FFFF;
    run_instr(K_NOP, 0, 0, 1'b0, 32'h0);
    chk("cnt_wrap", instr_cnt, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
